// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types for the SDRAM request arbiter.
// Grant-state encoding, bus widths and the loader FIFO entry.
package sdram_arb_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE_SLOT,
        CPU_SLOT,
        PPU_SLOT,
        LDR_SLOT
    } slot_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ldr_entry_t;

endpackage

// File: rtl/sdram_ldr_fifo.sv
// sdram_ldr_fifo: loader write queue in front of the arbiter.
// Full is registered; a write while full is dropped and flagged.
module sdram_ldr_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  ldr_entry_t din,
    input  logic       pop,
    output ldr_entry_t dout,
    output logic       full,
    output logic       empty,
    output logic       ovf
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ldr_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          do_wr;
    logic          do_pop;

    assign do_wr     = wr & ~full;
    assign do_pop    = pop & ~empty;
    assign empty     = (count == '0);
    assign dout      = mem[rd_ptr];
    assign count_nxt = count + (AW+1)'(do_wr) - (AW+1)'(do_pop);

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, full flag and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            if (wr && full) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arb.sv
// sdram_arb: slot-based CPU/PPU/loader arbiter in front of the SDRAM controller.
// Define SDRAM_ARB_LOADER_EN to build the loader FIFO and loader grants.
module sdram_arb
    import sdram_arb_pkg::*;
#(
    parameter int REFRESH_SLOTS = 8,
    parameter int LDR_DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clkref,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic              ppu_req,
    input  logic              ppu_we,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic [DATA_W-1:0] ppu_din,
    output logic              ppu_ack,
    output logic [DATA_W-1:0] ppu_dout,
    input  logic              ldr_wr,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_data,
    output logic              ldr_full,
    output logic              ldr_ovf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_oeA,
    output logic              mem_oeB,
    input  logic [DATA_W-1:0] mem_doutA,
    input  logic [DATA_W-1:0] mem_doutB
);
    localparam int CW = $clog2(REFRESH_SLOTS + 1);

    slot_t         state;
    slot_t         nxt;
    logic          clkref_d;
    logic          slot_start;
    logic [CW-1:0] access_cnt;
    logic          cpu_ok;
    logic          ppu_ok;
    logic          ldr_ok;
    logic          ldr_force;
    logic          fifo_full;
    logic          fifo_empty;
    ldr_entry_t    fifo_dout;

    assign slot_start = clkref & ~clkref_d;

`ifdef SDRAM_ARB_LOADER_EN
    logic       fifo_pop;
    logic       fifo_ovf;
    ldr_entry_t fifo_din;

    assign fifo_pop = slot_start & (state == LDR_SLOT);
    assign fifo_din = {ldr_addr, ldr_data};

    sdram_ldr_fifo #(
        .DEPTH (LDR_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (ldr_wr),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .ovf   (fifo_ovf)
    );

    assign ldr_full = fifo_full;
    assign ldr_ovf  = fifo_ovf;
`else
    logic unused_ldr;

    assign unused_ldr = ^{ldr_wr, ldr_addr, ldr_data, LDR_DEPTH[0]};
    assign fifo_full  = 1'b0;
    assign fifo_empty = 1'b1;
    assign fifo_dout  = '0;
    assign ldr_full   = 1'b1;
    assign ldr_ovf    = 1'b0;
`endif

    // Register clkref so its rising edge can be found.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkref_d <= 1'b0;
        end else begin
            clkref_d <= clkref;
        end
    end

    // Choose the next slot owner; a port completing now sits this one out.
    always_comb begin
        cpu_ok    = cpu_req & (state != CPU_SLOT);
        ppu_ok    = ppu_req & (state != PPU_SLOT);
        ldr_ok    = ~fifo_empty & (state != LDR_SLOT);
        ldr_force = fifo_full & (state != LDR_SLOT);
        nxt       = IDLE_SLOT;
        if (access_cnt == CW'(REFRESH_SLOTS)) begin
            nxt = IDLE_SLOT;
        end else if (ldr_force) begin
            nxt = LDR_SLOT;
        end else if (ppu_ok) begin
            nxt = PPU_SLOT;
        end else if (cpu_ok) begin
            nxt = CPU_SLOT;
        end else if (ldr_ok) begin
            nxt = LDR_SLOT;
        end
    end

    // Grant FSM: at each slot start, retire the old slot and drive the new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE_SLOT;
            access_cnt <= '0;
            cpu_ack    <= 1'b0;
            ppu_ack    <= 1'b0;
            cpu_dout   <= '0;
            ppu_dout   <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_we     <= 1'b0;
            mem_oeA    <= 1'b0;
            mem_oeB    <= 1'b0;
        end else if (slot_start) begin
            cpu_ack <= (state == CPU_SLOT);
            ppu_ack <= (state == PPU_SLOT);
            if (state == CPU_SLOT && mem_oeA) begin
                cpu_dout <= mem_doutA;
            end
            if (state == PPU_SLOT && mem_oeB) begin
                ppu_dout <= mem_doutB;
            end
            state <= nxt;
            if (nxt == IDLE_SLOT) begin
                access_cnt <= '0;
            end else if (access_cnt != CW'(REFRESH_SLOTS)) begin
                access_cnt <= access_cnt + 1'b1;
            end
            unique case (nxt)
                CPU_SLOT: begin
                    mem_addr <= cpu_addr;
                    mem_din  <= cpu_din;
                    mem_we   <= cpu_we;
                    mem_oeA  <= ~cpu_we;
                    mem_oeB  <= 1'b0;
                end
                PPU_SLOT: begin
                    mem_addr <= ppu_addr;
                    mem_din  <= ppu_din;
                    mem_we   <= ppu_we;
                    mem_oeA  <= 1'b0;
                    mem_oeB  <= ~ppu_we;
                end
                LDR_SLOT: begin
                    mem_addr <= fifo_dout.addr;
                    mem_din  <= fifo_dout.data;
                    mem_we   <= 1'b1;
                    mem_oeA  <= 1'b0;
                    mem_oeB  <= 1'b0;
                end
                default: begin
                    mem_we  <= 1'b0;
                    mem_oeA <= 1'b0;
                    mem_oeB <= 1'b0;
                end
            endcase
        end else begin
            cpu_ack <= 1'b0;
            ppu_ack <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: directed stimulus with a queue-based ack scoreboard.
// Loader cases follow SDRAM_ARB_LOADER_EN, like the design.
`timescale 1ns/1ps
module tb_sdram_arb;

`ifdef SDRAM_ARB_LOADER_EN
    localparam bit LDR_EN = 1'b1;
`else
    localparam bit LDR_EN = 1'b0;
`endif

    typedef struct packed {
        logic       rd;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clkref = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [24:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_dout;
    logic        ppu_req = 1'b0;
    logic        ppu_we = 1'b0;
    logic [24:0] ppu_addr = '0;
    logic [7:0]  ppu_din = '0;
    logic        ppu_ack;
    logic [7:0]  ppu_dout;
    logic        ldr_wr = 1'b0;
    logic [24:0] ldr_addr = '0;
    logic [7:0]  ldr_data = '0;
    logic        ldr_full;
    logic        ldr_ovf;
    logic [24:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic        mem_oeA;
    logic        mem_oeB;
    logic [7:0]  mem_doutA = '0;
    logic [7:0]  mem_doutB = '0;

    int   checks = 0;
    int   errors = 0;
    int   cpu_acks = 0;
    int   ppu_acks = 0;
    bit   stop = 1'b0;
    logic cpu_ack_prev = 1'b0;
    logic ppu_ack_prev = 1'b0;
    exp_t cpu_q[$];
    exp_t ppu_q[$];

    int exp_seq [20] = '{2, 1, 2, 1, 2, 1, 2, 1, 0,
                         2, 1, 2, 1, 2, 1, 2, 1, 0, 2, 1};

    sdram_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clkref    (clkref),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_ack   (cpu_ack),
        .cpu_dout  (cpu_dout),
        .ppu_req   (ppu_req),
        .ppu_we    (ppu_we),
        .ppu_addr  (ppu_addr),
        .ppu_din   (ppu_din),
        .ppu_ack   (ppu_ack),
        .ppu_dout  (ppu_dout),
        .ldr_wr    (ldr_wr),
        .ldr_addr  (ldr_addr),
        .ldr_data  (ldr_data),
        .ldr_full  (ldr_full),
        .ldr_ovf   (ldr_ovf),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_din   (mem_din),
        .mem_oeA   (mem_oeA),
        .mem_oeB   (mem_oeB),
        .mem_doutA (mem_doutA),
        .mem_doutB (mem_doutB)
    );

    always #5 clk = ~clk;

    // Slot reference: 8 clk per slot, edges just after clk rises.
    initial begin
        forever begin
            repeat (4) @(posedge clk);
            #1 clkref = ~clkref;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per ack.
    always @(negedge clk) begin
        exp_t e;
        if (mem_oeA || mem_oeB) begin
            chk("oe_exclusive", 32'(mem_oeA & mem_oeB), 0);
        end
        if (cpu_ack) begin
            cpu_acks++;
            chk("cpu_ack_width", 32'(cpu_ack_prev), 0);
            chk("cpu_ack_pending", 32'(cpu_q.size() != 0), 1);
            if (cpu_q.size() != 0) begin
                e = cpu_q.pop_front();
                if (e.rd) chk("cpu_dout", cpu_dout, e.data);
            end
        end
        if (ppu_ack) begin
            ppu_acks++;
            chk("ppu_ack_width", 32'(ppu_ack_prev), 0);
            chk("ppu_ack_pending", 32'(ppu_q.size() != 0), 1);
            if (ppu_q.size() != 0) begin
                e = ppu_q.pop_front();
                if (e.rd) chk("ppu_dout", ppu_dout, e.data);
            end
        end
        cpu_ack_prev = cpu_ack;
        ppu_ack_prev = ppu_ack;
    end

    task automatic wait_ack(input bit ppu, input int base, output bit ok);
        int n = 0;
        while (((ppu ? ppu_acks : cpu_acks) == base) && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = ((ppu ? ppu_acks : cpu_acks) != base);
        chk(ppu ? "ppu_ack_seen" : "cpu_ack_seen", 32'(ok), 1);
    endtask

    task automatic cpu_access(input logic we, input logic [24:0] a,
                              input logic [7:0] d, input logic [7:0] x);
        bit ok;
        int base = cpu_acks;
        cpu_we = we;
        cpu_addr = a;
        cpu_din = d;
        cpu_q.push_back({~we, x});
        cpu_req = 1'b1;
        wait_ack(1'b0, base, ok);
        cpu_req = 1'b0;
    endtask

    task automatic ppu_access(input logic we, input logic [24:0] a,
                              input logic [7:0] d, input logic [7:0] x);
        bit ok;
        int base = ppu_acks;
        ppu_we = we;
        ppu_addr = a;
        ppu_din = d;
        ppu_q.push_back({~we, x});
        ppu_req = 1'b1;
        wait_ack(1'b1, base, ok);
        ppu_req = 1'b0;
    endtask

    task automatic stream(input bit ppu);
        bit ok = 1'b1;
        bit go = 1'b1;
        int base;
        if (ppu) begin
            ppu_we = 1'b0;
            ppu_addr = 25'h0300;
            ppu_req = 1'b1;
        end else begin
            cpu_we = 1'b0;
            cpu_addr = 25'h0200;
            cpu_req = 1'b1;
        end
        while (go) begin
            base = ppu ? ppu_acks : cpu_acks;
            if (ppu) ppu_q.push_back({1'b1, 8'h22});
            else cpu_q.push_back({1'b1, 8'h11});
            wait_ack(ppu, base, ok);
            go = ok && !stop;
        end
        if (ppu) ppu_req = 1'b0;
        else cpu_req = 1'b0;
    endtask

    task automatic slot_mid();
        @(posedge clkref);
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_mem_addr"}, mem_addr, 0);
        chk({t, "_mem_din"}, mem_din, 0);
        chk({t, "_mem_we"}, mem_we, 0);
        chk({t, "_mem_oeA"}, mem_oeA, 0);
        chk({t, "_mem_oeB"}, mem_oeB, 0);
        chk({t, "_cpu_ack"}, cpu_ack, 0);
        chk({t, "_ppu_ack"}, ppu_ack, 0);
        chk({t, "_cpu_dout"}, cpu_dout, 0);
        chk({t, "_ppu_dout"}, ppu_dout, 0);
        chk({t, "_ldr_full"}, ldr_full, LDR_EN ? 0 : 1);
        chk({t, "_ldr_ovf"}, ldr_ovf, 0);
    endtask

    initial begin
        int n;
        int cls;
        int base;
        bit any_we;

        repeat (3) @(negedge clk);
        chk_zero("rst0");
        rst_n = 1'b1;

        // CPU read at 0x123 returning 0xA5.
        @(posedge clkref);
        @(negedge clk);
        mem_doutA = 8'hA5;
        fork
            cpu_access(1'b0, 25'h0000123, 8'h00, 8'hA5);
            begin
                n = 0;
                while (!mem_oeA && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                chk("t1_oeA_seen", 32'(mem_oeA), 1);
                chk("t1_addr", mem_addr, 25'h0000123);
                n = 0;
                while (mem_oeA && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("t1_slot_len", n, 8);
            end
        join

        // PPU write and CPU read raised together: PPU first.
        @(negedge clk);
        mem_doutA = 8'h5C;
        fork
            ppu_access(1'b1, 25'h0000456, 8'h9D, 8'h00);
            cpu_access(1'b0, 25'h0000789, 8'h00, 8'h5C);
            begin
                slot_mid();
                chk("t2_ppu_oeA", mem_oeA, 0);
                chk("t2_ppu_oeB", mem_oeB, 0);
                chk("t2_ppu_addr", mem_addr, 25'h0000456);
                chk("t2_ppu_din", mem_din, 8'h9D);
                slot_mid();
                chk("t2_cpu_oeA", mem_oeA, 1);
                chk("t2_cpu_oeB", mem_oeB, 0);
                chk("t2_cpu_addr", mem_addr, 25'h0000789);
            end
        join

        // Continuous CPU and PPU reads: idle slot after 8 accesses.
        @(negedge clk);
        mem_doutA = 8'h11;
        mem_doutB = 8'h22;
        stop = 1'b0;
        fork
            stream(1'b0);
            stream(1'b1);
            begin
                for (int i = 0; i < 20; i++) begin
                    slot_mid();
                    cls = mem_oeB ? 2 : mem_oeA ? 1 : mem_we ? 3 : 0;
                    chk($sformatf("t3_slot%0d", i), cls, exp_seq[i]);
                end
                stop = 1'b1;
            end
        join

`ifdef SDRAM_ARB_LOADER_EN
        // Five loader writes into a 4-deep FIFO within one slot.
        @(posedge clkref);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            ldr_wr = 1'b1;
            ldr_addr = 25'h0000100 + 25'(i);
            ldr_data = 8'h40 + 8'(i);
            @(negedge clk);
            if (i == 2) chk("t4_full_after3", ldr_full, 0);
            if (i == 3) chk("t4_full_after4", ldr_full, 1);
        end
        ldr_wr = 1'b0;
        @(negedge clk);
        chk("t4_ovf", ldr_ovf, 1);
        mem_doutB = 8'h77;
        fork
            ppu_access(1'b0, 25'h0000ABC, 8'h00, 8'h77);
            begin
                slot_mid();
                chk("t4_ldr_we", mem_we, 1);
                chk("t4_ldr_oeB", mem_oeB, 0);
                chk("t4_ldr_addr", mem_addr, 25'h0000100);
                chk("t4_ldr_din", mem_din, 8'h40);
                slot_mid();
                chk("t4_ppu_oeB", mem_oeB, 1);
                chk("t4_ppu_addr", mem_addr, 25'h0000ABC);
                slot_mid();
                chk("t4_ldr2_we", mem_we, 1);
                chk("t4_ldr2_addr", mem_addr, 25'h0000101);
            end
        join
        repeat (8) @(posedge clkref);
        @(negedge clk);
        chk("t4_drained_full", ldr_full, 0);
        chk("t4_ovf_sticky", ldr_ovf, 1);
`else
        // Loader strobes are ignored when the loader is not built.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            ldr_wr = 1'b1;
            ldr_addr = 25'h0000100 + 25'(i);
            ldr_data = 8'h40 + 8'(i);
            @(negedge clk);
        end
        ldr_wr = 1'b0;
        any_we = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (mem_we) any_we = 1'b1;
        end
        chk("t4_noldr_we", 32'(any_we), 0);
        chk("t4_noldr_full", ldr_full, 1);
        chk("t4_noldr_ovf", ldr_ovf, 0);
`endif

        // Reset in the middle of a CPU slot, then a fresh request.
        @(negedge clk);
        mem_doutA = 8'hE1;
        base = cpu_acks;
        cpu_we = 1'b0;
        cpu_addr = 25'h0000055;
        cpu_q.push_back({1'b1, 8'hE1});
        cpu_req = 1'b1;
        n = 0;
        while (!mem_oeA && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t5_oeA_seen", 32'(mem_oeA), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("t5_rst");
        cpu_q.delete();
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clkref);
        @(negedge clk);
        chk("t5_no_ack", cpu_acks - base, 0);
        mem_doutA = 8'h3C;
        cpu_access(1'b0, 25'h0000066, 8'h00, 8'h3C);

        repeat (2) @(posedge clkref);
        @(negedge clk);
        chk("end_cpu_q", cpu_q.size(), 0);
        chk("end_ppu_q", ppu_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
